// File: rtl/snax_csrman_queued.sv
// snax_csrman_queued: CSR manager with per-register shadow copies and a
// configuration queue. Each launch write commits the whole shadow set as one
// queue entry, so the core can program the next job while the accelerator
// still runs the current one. A status register reports queue occupancy.
module snax_csrman_queued #(
  parameter int unsigned NumRwCsr    = 7,
  parameter int unsigned NumRoCsr    = 4,
  parameter int unsigned CfgDepth    = 2,
  parameter logic [31:0] CsrBaseAddr = 32'h3c0,
  localparam int unsigned RoW        = (NumRoCsr > 0) ? NumRoCsr : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              csr_req_data_i,
  input  logic [31:0]              csr_req_addr_i,
  input  logic                     csr_req_write_i,
  input  logic                     csr_req_valid_i,
  output logic                     csr_req_ready_o,
  output logic [31:0]              csr_rsp_data_o,
  output logic                     csr_rsp_valid_o,
  input  logic                     csr_rsp_ready_i,
  output logic [NumRwCsr-1:0][31:0] csr_reg_rw_set_o,
  output logic                     csr_reg_set_valid_o,
  input  logic                     csr_reg_set_ready_i,
  input  logic [RoW-1:0][31:0]     csr_reg_ro_set_i
);

  localparam int unsigned PtrW = (CfgDepth > 1) ? $clog2(CfgDepth) : 1;
  localparam int unsigned CntW = $clog2(CfgDepth + 1);
  localparam logic [31:0] LaunchIdx = 32'(NumRwCsr);
  localparam logic [31:0] StatusIdx = 32'(NumRwCsr + NumRoCsr + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(CfgDepth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(CfgDepth);

  logic [NumRwCsr-1:0][31:0] shadow_r;
  logic [NumRwCsr-1:0][31:0] queue_r [CfgDepth];
  logic [PtrW-1:0]           wr_ptr_r;
  logic [PtrW-1:0]           rd_ptr_r;
  logic [CntW-1:0]           occ_r;
  logic                      rsp_valid_r;
  logic [31:0]               rsp_data_r;

  logic [31:0] idx_s;
  logic        is_launch_s;
  logic        is_status_s;
  logic        full_s;
  logic        empty_s;
  logic        rsp_block_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] rd_data_s;

  assign idx_s       = csr_req_addr_i - CsrBaseAddr;
  assign is_launch_s = (idx_s == LaunchIdx);
  assign is_status_s = (idx_s == StatusIdx);
  assign full_s      = (occ_r == DepthCnt);
  assign empty_s     = (occ_r == {CntW{1'b0}});
  assign rsp_block_s = rsp_valid_r && !csr_rsp_ready_i;

  // A launch into a full queue waits even if a pop happens this cycle.
  assign csr_req_ready_o = !rsp_block_s && !(csr_req_write_i && is_launch_s && full_s);
  assign accept_s        = csr_req_valid_i && csr_req_ready_o;
  assign push_s          = accept_s && csr_req_write_i && is_launch_s;
  assign pop_s           = !empty_s && csr_reg_set_ready_i;

  assign csr_rsp_valid_o     = rsp_valid_r;
  assign csr_rsp_data_o      = rsp_data_r;
  assign csr_reg_set_valid_o = !empty_s;
  assign csr_reg_rw_set_o    = empty_s ? '0 : queue_r[rd_ptr_r];

  // Read mux: decoded regions are disjoint, so OR-accumulating hits is exact.
  always_comb begin
    rd_data_s = 32'd0;
    for (int i = 0; i < NumRwCsr; i++) begin
      rd_data_s = rd_data_s | ((idx_s == 32'(i)) ? shadow_r[i] : 32'd0);
    end
    for (int i = 0; i < NumRoCsr; i++) begin
      rd_data_s = rd_data_s |
                  ((idx_s == (LaunchIdx + 32'(i) + 32'd1)) ? csr_reg_ro_set_i[i] : 32'd0);
    end
    rd_data_s = rd_data_s |
                (is_status_s ? {14'd0, empty_s, full_s, 16'(occ_r)} : 32'd0);
  end

  // Shadow registers capture accepted writes to their own index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_r <= '0;
    end else begin
      for (int i = 0; i < NumRwCsr; i++) begin
        if (accept_s && csr_req_write_i && (idx_s == 32'(i))) begin
          shadow_r[i] <= csr_req_data_i;
        end
      end
    end
  end

  // Configuration queue: circular buffer with wrapping pointers and a counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CfgDepth; i++) begin
        queue_r[i] <= '0;
      end
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      occ_r    <= {CntW{1'b0}};
    end else begin
      if (push_s) begin
        queue_r[wr_ptr_r] <= shadow_r;
        wr_ptr_r <= (wr_ptr_r == LastPtr) ? {PtrW{1'b0}} : wr_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LastPtr) ? {PtrW{1'b0}} : rd_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
      end
      if (push_s && !pop_s) begin
        occ_r <= occ_r + {{(CntW-1){1'b0}}, 1'b1};
      end else if (pop_s && !push_s) begin
        occ_r <= occ_r - {{(CntW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read response register: loaded on an accepted read, held until consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
    end else begin
      if (accept_s && !csr_req_write_i) begin
        rsp_valid_r <= 1'b1;
        rsp_data_r  <= rd_data_s;
      end else if (csr_rsp_ready_i) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

endmodule
